traffic_light_monitor: RTL and testbench

// Receive-side checker for the R/G/Y lamp outputs of the traffic light controller.
// - Samples the lamp lines and the pass request every clock.
// - Reconstructs the controller phase: G1, N1, G2, N2, G3, Y1, R1.
// - Measures how long each phase lasts and flags illegal lamp codes, out-of-order phases and bad durations.
// - Sits beside the controller in the top level and in the system bench. It only observes and never drives the controller.

---
 rtl/traffic_light_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the controller's R/G/Y lamp lines: tracks the G1..R1 phase sequence,
// times each phase and flags illegal codes. Optional sticky error status under TLM_STICKY_ERR_EN.
module traffic_light_monitor #(
    parameter int unsigned T_G1  = 1024,
    parameter int unsigned T_BL  = 128,
    parameter int unsigned T_Y1  = 512,
    parameter int unsigned T_R1  = 1024,
    parameter int unsigned TOL   = 2,
    parameter int unsigned CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        R,
    input  logic        G,
    input  logic        Y,
    input  logic        pass,
    output logic [2:0]  phase,
    output logic        in_sync,
    output logic        seq_err,
    output logic        dur_err,
    output logic        illegal_err,
    output logic [15:0] cycles_ok
`ifdef TLM_STICKY_ERR_EN
    ,
    output logic [2:0]  err_status,
    input  logic        err_clr
`endif
);

    typedef enum logic [2:0] {
        PH_G1   = 3'd0,
        PH_N1   = 3'd1,
        PH_G2   = 3'd2,
        PH_N2   = 3'd3,
        PH_G3   = 3'd4,
        PH_Y1   = 3'd5,
        PH_R1   = 3'd6,
        PH_SYNC = 3'd7
    } phase_t;

    localparam logic [2:0] C_DARK = 3'b000;
    localparam logic [2:0] C_GRN  = 3'b010;
    localparam logic [2:0] C_YEL  = 3'b001;
    localparam logic [2:0] C_RED  = 3'b100;

    // Lamp code the next phase must show.
    function automatic logic [2:0] exp_code(input phase_t p);
        case (p)
            PH_G1:   exp_code = C_DARK;
            PH_N1:   exp_code = C_GRN;
            PH_G2:   exp_code = C_DARK;
            PH_N2:   exp_code = C_GRN;
            PH_G3:   exp_code = C_YEL;
            PH_Y1:   exp_code = C_RED;
            PH_R1:   exp_code = C_GRN;
            default: exp_code = C_DARK;
        endcase
    endfunction

    function automatic phase_t succ(input phase_t p);
        case (p)
            PH_G1:   succ = PH_N1;
            PH_N1:   succ = PH_G2;
            PH_G2:   succ = PH_N2;
            PH_N2:   succ = PH_G3;
            PH_G3:   succ = PH_Y1;
            PH_Y1:   succ = PH_R1;
            PH_R1:   succ = PH_G1;
            default: succ = PH_SYNC;
        endcase
    endfunction

    function automatic logic dur_in_range(input phase_t p, input logic [CNT_W-1:0] run);
        int unsigned t;
        int unsigned r;
        case (p)
            PH_G1:   t = T_G1;
            PH_Y1:   t = T_Y1;
            PH_R1:   t = T_R1;
            default: t = T_BL;
        endcase
        r = 32'(run);
        dur_in_range = (r + TOL >= t) && (r <= t + TOL);
    endfunction

    logic [2:0]       lamp_q, lamp_qq;
    logic             pass_q;
    logic [CNT_W-1:0] run_cnt;
    phase_t           state, state_nxt;
    logic             pend, pend_nxt;
    logic             g1_exempt, exempt_nxt;
    logic             clean, clean_nxt;
    logic             seq_nxt, dur_nxt, ill_nxt;
    logic [15:0]      cyc_nxt;
    logic             restart;
    logic             changed, legal, exempt_now;

    assign changed = (lamp_q != lamp_qq);
    assign legal   = lamp_q inside {C_DARK, C_GRN, C_YEL, C_RED};
    assign phase   = state;

    // Input sampling and run-length counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_q  <= 3'b000;
            lamp_qq <= 3'b000;
            pass_q  <= 1'b0;
            run_cnt <= '0;
        end else begin
            lamp_q  <= {R, G, Y};
            lamp_qq <= lamp_q;
            pass_q  <= pass;
            if (changed || restart)
                run_cnt <= CNT_W'(1);
            else if (run_cnt != {CNT_W{1'b1}})
                run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    // Phase tracker state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PH_SYNC;
            pend        <= 1'b0;
            g1_exempt   <= 1'b0;
            clean       <= 1'b0;
            in_sync     <= 1'b0;
            seq_err     <= 1'b0;
            dur_err     <= 1'b0;
            illegal_err <= 1'b0;
            cycles_ok   <= 16'd0;
        end else begin
            state       <= state_nxt;
            pend        <= pend_nxt;
            g1_exempt   <= exempt_nxt;
            clean       <= clean_nxt;
            in_sync     <= (state_nxt != PH_SYNC);
            seq_err     <= seq_nxt;
            dur_err     <= dur_nxt;
            illegal_err <= ill_nxt;
            cycles_ok   <= cyc_nxt;
        end
    end

`ifdef TLM_STICKY_ERR_EN
    // A pulse in the clearing clock re-sets its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_status <= 3'b000;
        else
            err_status <= (err_clr ? 3'b000 : err_status) | {ill_nxt, dur_nxt, seq_nxt};
    end
`endif

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        exempt_nxt = g1_exempt;
        clean_nxt  = clean;
        seq_nxt    = 1'b0;
        dur_nxt    = 1'b0;
        ill_nxt    = 1'b0;
        cyc_nxt    = cycles_ok;
        restart    = 1'b0;
        exempt_now = 1'b0;

        if (!legal) begin
            ill_nxt   = changed;
            state_nxt = PH_SYNC;
            pend_nxt  = 1'b0;
        end else if (state == PH_SYNC) begin
            if (lamp_q == C_GRN && (lamp_qq == C_RED || pass_q)) begin
                state_nxt  = PH_G1;
                restart    = 1'b1;
                pend_nxt   = 1'b0;
                exempt_nxt = pass_q;
                clean_nxt  = !pass_q;
            end
        end else if (pend || (pass_q && state != PH_G1)) begin
            // Pass abort: green must show now or on the following clock.
            if (lamp_q == C_GRN) begin
                state_nxt  = PH_G1;
                restart    = 1'b1;
                pend_nxt   = 1'b0;
                exempt_nxt = 1'b1;
                clean_nxt  = 1'b0;
            end else if (pend) begin
                seq_nxt   = 1'b1;
                state_nxt = PH_SYNC;
                pend_nxt  = 1'b0;
            end else begin
                pend_nxt = 1'b1;
            end
        end else begin
            if (pass_q) begin
                exempt_nxt = 1'b1;
                clean_nxt  = 1'b0;
            end
            if (changed) begin
                if (lamp_q != exp_code(state)) begin
                    seq_nxt   = 1'b1;
                    state_nxt = PH_SYNC;
                end else begin
                    exempt_now = (state == PH_G1) && (g1_exempt || pass_q);
                    if (!exempt_now && !dur_in_range(state, run_cnt)) begin
                        dur_nxt   = 1'b1;
                        clean_nxt = 1'b0;
                    end
                    if (state == PH_R1) begin
                        if (clean && !dur_nxt && !pass_q)
                            cyc_nxt = cycles_ok + 16'd1;
                        clean_nxt = 1'b1;
                    end
                    exempt_nxt = 1'b0;
                    state_nxt  = succ(state);
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: table of lamp segments with expected tracker outputs,
// checked through a scoreboard two clocks after each segment starts.
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        R = 1'b0, G = 1'b0, Y = 1'b0, pass = 1'b0;
    logic [2:0]  phase;
    logic        in_sync, seq_err, dur_err, illegal_err;
    logic [15:0] cycles_ok;
`ifdef TLM_STICKY_ERR_EN
    logic [2:0]  err_status;
    logic        err_clr = 1'b0;
`endif

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .R(R), .G(G), .Y(Y), .pass(pass),
        .phase(phase), .in_sync(in_sync), .seq_err(seq_err), .dur_err(dur_err),
        .illegal_err(illegal_err), .cycles_ok(cycles_ok)
`ifdef TLM_STICKY_ERR_EN
        , .err_status(err_status), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2:0] DRK = 3'b000, GRN = 3'b010, YEL = 3'b001, RED = 3'b100, ILL = 3'b110;

    typedef struct {
        logic [2:0] code; logic p; int len;
        logic [2:0] ph; logic sy, se, de, ie; int cok;
    } vec_t;
    typedef struct {
        int due; int row;
        logic [2:0] ph; logic sy, se, de, ie; int cok;
    } exp_t;

    vec_t tbl[80];
    int   ntbl = 0;
    exp_t sbq[$];
    int   total = 0, bad = 0;
    int   n_seq = 0, n_dur = 0, n_ill = 0;

    function automatic void add(input logic [2:0] code, input logic p, input int len,
                                input logic [2:0] ph, input logic sy, input logic se,
                                input logic de, input logic ie, input int cok);
        tbl[ntbl] = '{code, p, len, ph, sy, se, de, ie, cok};
        ntbl++;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0d want=%0d (t=%0t)", nm, row, act, exp, $time);
        end
    endtask

    // Pulse counters plus scoreboard pop at the due cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (seq_err)     n_seq++;
        if (dur_err)     n_dur++;
        if (illegal_err) n_ill++;
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("due", e.row, cyc, e.due);
            chk("phase", e.row, int'(phase), int'(e.ph));
            chk("in_sync", e.row, int'(in_sync), int'(e.sy));
            chk("seq_err", e.row, int'(seq_err), int'(e.se));
            chk("dur_err", e.row, int'(dur_err), int'(e.de));
            chk("illegal_err", e.row, int'(illegal_err), int'(e.ie));
            chk("cycles_ok", e.row, int'(cycles_ok), e.cok);
        end
    end

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            {R, G, Y} = tbl[i].code;
            pass = tbl[i].p;
            sbq.push_back('{cyc + 2, i, tbl[i].ph, tbl[i].sy, tbl[i].se, tbl[i].de, tbl[i].ie, tbl[i].cok});
            repeat (tbl[i].len) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input int tag);
        chk("rst_phase", tag, int'(phase), 7);
        chk("rst_in_sync", tag, int'(in_sync), 0);
        chk("rst_seq", tag, int'(seq_err), 0);
        chk("rst_dur", tag, int'(dur_err), 0);
        chk("rst_ill", tag, int'(illegal_err), 0);
        chk("rst_cycles_ok", tag, int'(cycles_ok), 0);
`ifdef TLM_STICKY_ERR_EN
        chk("rst_err_status", tag, int'(err_status), 0);
`endif
    endtask

    int a_end, e_end;

    initial begin
        // Three ideal cycles after a red lead-in.
        add(RED, 0, 300, 7, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(GRN, 0, 1024, 0, 1, 0, 0, 0, k);
            add(DRK, 0, 128,  1, 1, 0, 0, 0, k);
            add(GRN, 0, 128,  2, 1, 0, 0, 0, k);
            add(DRK, 0, 128,  3, 1, 0, 0, 0, k);
            add(GRN, 0, 128,  4, 1, 0, 0, 0, k);
            add(YEL, 0, 512,  5, 1, 0, 0, 0, k);
            add(RED, 0, 1024, 6, 1, 0, 0, 0, k);
        end
        // Tolerance edges (130, 126 pass) and a short Y1 (500 fails).
        add(GRN, 0, 1024, 0, 1, 0, 0, 0, 3);
        add(DRK, 0, 130,  1, 1, 0, 0, 0, 3);
        add(GRN, 0, 126,  2, 1, 0, 0, 0, 3);
        add(DRK, 0, 128,  3, 1, 0, 0, 0, 3);
        add(GRN, 0, 128,  4, 1, 0, 0, 0, 3);
        add(YEL, 0, 500,  5, 1, 0, 0, 0, 3);
        add(RED, 0, 1024, 6, 1, 0, 1, 0, 3);
        // Dirty cycle does not count; illegal code in G2; resync at next red->green.
        add(GRN, 0, 1024, 0, 1, 0, 0, 0, 3);
        add(DRK, 0, 128,  1, 1, 0, 0, 0, 3);
        add(GRN, 0, 50,   2, 1, 0, 0, 0, 3);
        add(ILL, 0, 1,    7, 0, 0, 0, 1, 3);
        add(GRN, 0, 77,   7, 0, 0, 0, 0, 3);
        add(DRK, 0, 128,  7, 0, 0, 0, 0, 3);
        add(GRN, 0, 128,  7, 0, 0, 0, 0, 3);
        add(YEL, 0, 512,  7, 0, 0, 0, 0, 3);
        add(RED, 0, 1024, 7, 0, 0, 0, 0, 3);
        add(GRN, 0, 1024, 0, 1, 0, 0, 0, 3);
        // Pass in Y1, green follows one clock later.
        add(DRK, 0, 128,  1, 1, 0, 0, 0, 3);
        add(GRN, 0, 128,  2, 1, 0, 0, 0, 3);
        add(DRK, 0, 128,  3, 1, 0, 0, 0, 3);
        add(GRN, 0, 128,  4, 1, 0, 0, 0, 3);
        add(YEL, 0, 200,  5, 1, 0, 0, 0, 3);
        add(YEL, 1, 1,    5, 1, 0, 0, 0, 3);
        add(GRN, 0, 1024, 0, 1, 0, 0, 0, 3);
        // N1 jumps to yellow, then resync and run into R1.
        add(DRK, 0, 128,  1, 1, 0, 0, 0, 3);
        add(YEL, 0, 300,  7, 0, 1, 0, 0, 3);
        add(RED, 0, 500,  7, 0, 0, 0, 0, 3);
        add(GRN, 0, 1024, 0, 1, 0, 0, 0, 3);
        add(DRK, 0, 128,  1, 1, 0, 0, 0, 3);
        add(GRN, 0, 128,  2, 1, 0, 0, 0, 3);
        add(DRK, 0, 128,  3, 1, 0, 0, 0, 3);
        add(GRN, 0, 128,  4, 1, 0, 0, 0, 3);
        add(YEL, 0, 512,  5, 1, 0, 0, 0, 3);
        add(RED, 0, 600,  6, 1, 0, 0, 0, 3);
        e_end = ntbl;
        // After mid-run reset: G1 one clock past tolerance.
        add(RED, 0, 300,  7, 0, 0, 0, 0, 0);
        add(GRN, 0, 1027, 0, 1, 0, 0, 0, 0);
        add(DRK, 0, 128,  1, 1, 0, 1, 0, 0);
        a_end = ntbl;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_reset(-1);
        rst = 1'b0;

        run_rows(0, e_end);
        chk("sb_drained_pre_rst", -2, sbq.size(), 0);

        rst = 1'b1;
        #1;
        chk_reset(-3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_rows(e_end, a_end);

`ifdef TLM_STICKY_ERR_EN
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("err_status_held", i, int'(err_status), 2);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_status_clr", -4, int'(err_status), 0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", -5, sbq.size(), 0);
        chk("seq_total", -6, n_seq, 1);
        chk("dur_total", -7, n_dur, 2);
        chk("ill_total", -8, n_ill, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
